// File: rtl/gain_control_loop.sv
// Closed-loop AGC: windowed mean |din|, error integrator, piecewise-log gain code.
// Optional GAIN_LOOP_LOCK_EN adds the loop-settled lock indicator.
module gain_control_loop #(
    parameter int          INTEG_W   = 24,
    parameter logic [20:0] INIT_GAIN = 21'h0F_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkEn,
    input  logic [17:0] din,
    input  logic [16:0] setpoint,
    input  logic [3:0]  windowLog2,
    input  logic [3:0]  loopShift,
    input  logic        freeze,
    input  logic        manualEn,
    input  logic [20:0] manualGain,
    output logic [4:0]  exponent,
    output logic [15:0] mantissa,
    output logic        update,
    output logic        railHigh,
    output logic        railLow,
    output logic        lock
);

    localparam int SW  = INTEG_W + 2;
    localparam int LSB = INTEG_W - 21;
    localparam logic [INTEG_W-1:0] INIT_INTEG =
        INTEG_W'(INIT_GAIN) << LSB;
    localparam logic signed [SW-1:0] MAXV = SW'({INTEG_W{1'b1}});

    logic [16:0] absDin;
    logic [16:0] mag;
    logic        magValid;

    // Most negative input saturates to the largest magnitude
    always_comb begin
        if (din == 18'h20000)
            absDin = 17'h1ffff;
        else if (din[17])
            absDin = 17'(-din);
        else
            absDin = din[16:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag      <= '0;
            magValid <= 1'b0;
        end else if (clkEn) begin
            mag      <= absDin;
            magValid <= 1'b1;
        end
    end

    logic [31:0] acc;
    logic [31:0] total;
    logic [14:0] cnt;
    logic [14:0] lastCnt;
    logic [3:0]  nLat;
    logic [3:0]  nEff;
    logic        term;
    logic [16:0] avg;
    logic        avgValid;

    always_comb begin
        nEff    = (cnt == 15'd0) ? windowLog2 : nLat;
        lastCnt = 15'((16'd1 << nEff) - 16'd1);
        term    = (cnt == lastCnt);
        total   = acc + 32'(mag);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            cnt      <= '0;
            nLat     <= '0;
            avg      <= '0;
            avgValid <= 1'b0;
        end else if (clkEn) begin
            avgValid <= magValid && term;
            if (magValid) begin
                if (cnt == 15'd0)
                    nLat <= windowLog2;
                if (term) begin
                    acc <= '0;
                    cnt <= '0;
                    avg <= 17'(total >> nEff);
                end else begin
                    acc <= total;
                    cnt <= cnt + 15'd1;
                end
            end
        end
    end

    logic signed [18:0] err;
    logic               errValid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err      <= '0;
            errValid <= 1'b0;
        end else if (clkEn) begin
            errValid <= avgValid;
            if (avgValid)
                err <= {2'b00, setpoint} - {2'b00, avg};
        end
    end

    logic signed [SW-1:0] step;
    logic signed [SW-1:0] sum;
    logic [INTEG_W-1:0]   integ;
    logic [INTEG_W-1:0]   integNext;
    logic [20:0]          gain;
    logic                 clipHi;
    logic                 clipLo;

    always_comb begin
        step      = SW'(err) >>> loopShift;
        sum       = $signed({2'b00, integ}) + step;
        clipHi    = 1'b0;
        clipLo    = 1'b0;
        integNext = sum[INTEG_W-1:0];
        if (sum[SW-1]) begin
            clipLo    = 1'b1;
            integNext = '0;
        end else if (sum > MAXV) begin
            clipHi    = 1'b1;
            integNext = '1;
        end
    end

    // Manual mode keeps the integrator tracking for a bumpless release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            integ    <= INIT_INTEG;
            gain     <= INIT_GAIN;
            update   <= 1'b0;
            railHigh <= 1'b0;
            railLow  <= 1'b0;
        end else begin
            update <= 1'b0;
            if (clkEn) begin
                if (manualEn) begin
                    integ <= INTEG_W'(manualGain) << LSB;
                    gain  <= manualGain;
                end else if (errValid && !freeze) begin
                    integ    <= integNext;
                    gain     <= integNext[INTEG_W-1 -: 21];
                    update   <= 1'b1;
                    railHigh <= clipHi;
                    railLow  <= clipLo;
                end
            end
        end
    end

    assign exponent = gain[20:16];
    assign mantissa = gain[15:0];

`ifdef GAIN_LOOP_LOCK_EN
    logic [2:0]  lockCnt;
    logic        lockR;
    logic [18:0] errMag;
    logic        inBand;

    always_comb begin
        errMag = err[18] ? 19'(-err) : 19'(err);
        inBand = errMag <= {5'd0, setpoint[16:3]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lockCnt <= '0;
            lockR   <= 1'b0;
        end else if (clkEn) begin
            if (manualEn) begin
                lockCnt <= '0;
                lockR   <= 1'b0;
            end else if (errValid && !freeze) begin
                if (inBand) begin
                    if (lockCnt != 3'd4)
                        lockCnt <= lockCnt + 3'd1;
                    lockR <= (lockCnt >= 3'd3);
                end else begin
                    lockCnt <= '0;
                    lockR   <= 1'b0;
                end
            end
        end
    end

    assign lock = lockR;
`else
    assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_gain_control_loop.sv
// Randomized bench for gain_control_loop with a window/queue level loop model.
// Lock checks follow GAIN_LOOP_LOCK_EN when it is defined.
module tb_gain_control_loop;

    logic        clk = 1'b0;
    logic        reset;
    logic        clkEn;
    logic [17:0] din;
    logic [16:0] setpoint;
    logic [3:0]  windowLog2;
    logic [3:0]  loopShift;
    logic        freeze;
    logic        manualEn;
    logic [20:0] manualGain;
    logic [4:0]  exponent;
    logic [15:0] mantissa;
    logic        update;
    logic        railHigh;
    logic        railLow;
    logic        lock;

    gain_control_loop dut (
        .clk(clk), .reset(reset), .clkEn(clkEn), .din(din),
        .setpoint(setpoint), .windowLog2(windowLog2),
        .loopShift(loopShift), .freeze(freeze),
        .manualEn(manualEn), .manualGain(manualGain),
        .exponent(exponent), .mantissa(mantissa), .update(update),
        .railHigh(railHigh), .railLow(railLow), .lock(lock)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_on = 0;
    bit rnd_en = 0;
    int upd_seen = 0;

    // Behavioural model: windows of samples, then two pipeline delays
    longint      m_integ;
    logic [20:0] m_gain;
    bit          m_upd, m_rh, m_rl, m_lock;
    int          m_lcnt;
    int          w_cnt, w_n, prev_mag, e;
    longint      w_sum;
    bit          have_prev;
    int          avg_q[$], avg_due[$], err_q[$], err_due[$];

    function automatic int mag_of(logic [17:0] d);
        int v;
        v = int'($signed(d));
        if (v < 0) v = -v;
        if (v > 131071) v = 131071;
        return v;
    endfunction

    task automatic model_reset();
        m_integ = longint'(21'h0F0000) * 8;
        m_gain = 21'h0F0000;
        m_upd = 0; m_rh = 0; m_rl = 0; m_lock = 0; m_lcnt = 0;
        w_cnt = 0; w_sum = 0; w_n = 0; have_prev = 0; e = 0;
        avg_q.delete(); avg_due.delete();
        err_q.delete(); err_due.delete();
    endtask

    task automatic model_edge();
        bit has_err;
        int ev, av;
        longint s;
        e++;
        m_upd = 0;
        has_err = (err_due.size() > 0) && (err_due[0] == e);
        ev = 0;
        if (has_err) begin
            ev = err_q.pop_front();
            void'(err_due.pop_front());
        end
        if (manualEn) begin
            m_integ = longint'(manualGain) * 8;
            m_gain = manualGain;
            m_lcnt = 0; m_lock = 0;
        end else if (has_err && !freeze) begin
            s = m_integ + (longint'(ev) >>> loopShift);
            m_rh = 0; m_rl = 0;
            if (s < 0) begin
                s = 0; m_rl = 1;
            end else if (s > 64'hFFFFFF) begin
                s = 64'hFFFFFF; m_rh = 1;
            end
            m_integ = s;
            m_gain = 21'(s >> 3);
            m_upd = 1;
`ifdef GAIN_LOOP_LOCK_EN
            if ((ev < 0 ? -ev : ev) <= int'(setpoint >> 3)) begin
                if (m_lcnt < 4) m_lcnt++;
                m_lock = (m_lcnt >= 4);
            end else begin
                m_lcnt = 0; m_lock = 0;
            end
`endif
        end
        if (avg_due.size() > 0 && avg_due[0] == e) begin
            av = avg_q.pop_front();
            void'(avg_due.pop_front());
            err_q.push_back(int'(setpoint) - av);
            err_due.push_back(e + 1);
        end
        if (have_prev) begin
            if (w_cnt == 0) w_n = int'(windowLog2);
            w_sum += prev_mag;
            w_cnt++;
            if (w_cnt == (1 << w_n)) begin
                avg_q.push_back(int'(w_sum >> w_n));
                avg_due.push_back(e + 1);
                w_cnt = 0;
                w_sum = 0;
            end
        end
        prev_mag = mag_of(din);
        have_prev = 1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("gain", 32'({exponent, mantissa}), 32'(m_gain));
            chk("update", 32'(update), 32'(m_upd));
            chk("railHigh", 32'(railHigh), 32'(m_rh));
            chk("railLow", 32'(railLow), 32'(m_rl));
            chk("lock", 32'(lock), 32'(m_lock));
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            if (!reset) begin
                if (clkEn) model_edge();
                else m_upd = 0;
            end
            #1;
            if (update === 1'b1) upd_seen++;
            if (rnd_en) clkEn = ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic wait_upd(input int maxc, output int cycles);
        bit got;
        got = 0;
        cycles = 0;
        while (!got && cycles < maxc) begin
            cyc(1);
            cycles++;
            got = (update === 1'b1);
        end
        chk("wait_update", 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        cyc(2);
        chk("rst_exponent", 32'(exponent), 32'd15);
        chk("rst_mantissa", 32'(mantissa), 32'd0);
        chk("rst_update", 32'(update), 32'd0);
        chk("rst_rails", 32'({railHigh, railLow}), 32'd0);
        chk("rst_lock", 32'(lock), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        int c;
        reset = 1'b1; clkEn = 0; din = '0; setpoint = '0;
        windowLog2 = 4'd4; loopShift = 4'd0; freeze = 0;
        manualEn = 0; manualGain = '0;
        model_reset();
        chk_on = 1;
        do_reset();

        // Step response
        din = 18'd1000; setpoint = 17'd4000; clkEn = 1;
        wait_upd(40, c);
        chk("step_first", 32'({exponent, mantissa}), 32'h0F0177);
        wait_upd(40, c);
        chk("step_period", 32'(c), 32'd16);
        chk("step_second", 32'({exponent, mantissa}), 32'h0F02EE);

        // Clip at both rails
        windowLog2 = 4'd0; din = '0; setpoint = 17'h1ffff;
        cyc(200);
        chk("clip_max", 32'({exponent, mantissa}), 32'h1FFFFF);
        chk("rail_high", 32'(railHigh), 32'd1);
        din = 18'h20000; setpoint = '0;
        cyc(200);
        chk("clip_zero", 32'({exponent, mantissa}), 32'd0);
        chk("rail_low", 32'({railHigh, railLow}), 32'd1);

        // Freeze, manual override, bumpless release
        freeze = 1; din = 18'd1000; setpoint = 17'd1800;
        windowLog2 = 4'd2; loopShift = 4'd3;
        upd_seen = 0;
        cyc(40);
        chk("freeze_pulses", 32'(upd_seen), 32'd0);
        chk("freeze_hold", 32'({exponent, mantissa}), 32'd0);
        manualEn = 1; manualGain = 21'h0A8000;
        cyc(2);
        chk("manual_exp", 32'(exponent), 32'd10);
        chk("manual_man", 32'(mantissa), 32'h8000);
        cyc(10);
        freeze = 0; manualEn = 0;
        wait_upd(20, c);
        chk("release", 32'({exponent, mantissa}), 32'h0A800C);

        // Gated clkEn with one-sample windows
        windowLog2 = 4'd0; loopShift = 4'd4; rnd_en = 1;
        for (int i = 0; i < 200; i++) begin
            din = 18'($urandom);
            cyc(1);
        end
        rnd_en = 0; clkEn = 1;

        // Window size change lands on the following window
        windowLog2 = 4'd3;
        cyc(5);
        windowLog2 = 4'd1;
        wait_upd(20, c);
        wait_upd(20, c);
        chk("n_change_period", 32'(c), 32'd2);

        // Largest window, then reset part-way into the next one
        windowLog2 = 4'd15; din = 18'd3000;
        setpoint = 17'd3100; loopShift = 4'd0;
        cyc(5);
        wait_upd(33000, c);
        cyc(100);
        do_reset();

        // Randomized operation
        for (int i = 0; i < 3000; i++) begin
            clkEn = ($urandom_range(0, 3) != 0);
            din = 18'($urandom_range(0, 6000));
            if ($urandom_range(0, 1) == 1) din = -din;
            if (i % 500 == 7) din = 18'h20000;
            if ($urandom_range(0, 99) == 0)
                setpoint = 17'($urandom_range(0, 8000));
            if ($urandom_range(0, 199) == 0)
                windowLog2 = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0)
                loopShift = 4'($urandom);
            freeze = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) manualEn = ~manualEn;
            manualGain = 21'($urandom);
            if (i == 1500) begin
                reset = 1'b1;
                model_reset();
                cyc(1);
                reset = 1'b0;
            end
            cyc(1);
        end

        manualEn = 0; freeze = 0; clkEn = 1;
        do_reset();
        din = 18'd4000; setpoint = 17'd4000;
        windowLog2 = 4'd2; loopShift = 4'd0;
        for (int k = 1; k <= 4; k++) begin
            wait_upd(20, c);
`ifdef GAIN_LOOP_LOCK_EN
            chk("lock_seq", 32'(lock), 32'(k == 4));
`endif
        end
        din = 18'd8000;
        cyc(12);
        chk("lock_drop", 32'(lock), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
